wrap_inst_buffer: RTL and testbench

- Per-wrap instruction buffer directly downstream of the fetch stage.
- Accepts one fetched instruction per cycle, tagged with wrap index and PC, into a small per-wrap FIFO.
- Returns a per-wrap ready mask to fetch; fetch ANDs it with its active mask before round-robin selection.
- Presents the head entry of each wrap to the issue stage, which pops one wrap per cycle; supports per-wrap flush on branch redirect.

---
 rtl/wrap_inst_buffer_pkg.sv | 19 +
 rtl/ibuf_wrap_fifo.sv | 73 +++++++
 rtl/wrap_inst_buffer.sv | 97 +++++++++
 tb/tb_wrap_inst_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wrap_inst_buffer_pkg.sv
// Shared types for the per-wrap instruction buffer.
//   NUM_WRAPS_PER_CORE : default number of wraps per core
//   scalar_t / inst_t  : 32-bit PC and instruction word
//   wrap_idx_t         : wrap index sized for NUM_WRAPS_PER_CORE
//   ibuf_entry_t       : one buffered instruction {pc, inst}
package wrap_inst_buffer_pkg;

  localparam int NUM_WRAPS_PER_CORE = 4;

  typedef logic [31:0] scalar_t;
  typedef logic [31:0] inst_t;
  typedef logic [$clog2(NUM_WRAPS_PER_CORE)-1:0] wrap_idx_t;

  typedef struct packed {
    scalar_t pc;
    inst_t   inst;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_wrap_fifo.sv
// Single-wrap instruction FIFO.
//   clk, reset  : clock, asynchronous active-high reset (control state only)
//   push        : enqueue push_data if not full
//   push_data   : entry to enqueue
//   pop         : dequeue head if not empty
//   flush       : clear pointers and count; a same-cycle push is discarded
//   head        : entry at rd_ptr (undefined when empty)
//   count       : occupancy 0..DEPTH
//   ready       : count < DEPTH-SKID (leaves SKID slots for in-flight fetches)
//   overflow    : push attempted while full (not flagged during a flush)
module ibuf_wrap_fifo
  import wrap_inst_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int SKID  = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  ibuf_entry_t       push_data,
  input  logic              pop,
  input  logic              flush,
  output ibuf_entry_t       head,
  output logic [CNT_W-1:0]  count,
  output logic              ready,
  output logic              overflow
);

  ibuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             not_full;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on the current count, so a push into a full FIFO is
  // dropped even if the same cycle pops it.
  assign not_full = (count < CNT_W'(DEPTH));
  assign do_push  = push & not_full;
  assign do_pop   = pop & (count != '0);
  assign overflow = push & ~not_full & ~flush;
  assign ready    = (count < CNT_W'(DEPTH - SKID));
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // A same-cycle pop is simply absorbed: everything ends empty.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wrap_inst_buffer.sv
// Per-wrap instruction buffer between fetch and issue.
//   clk, reset        : clock, asynchronous active-high reset
//   fetch_valid/_wrap_idx/_pc/_inst : one fetched instruction per cycle
//   ibuf_ready_mask   : per-wrap "may be selected by fetch" (registered state)
//   issue_valid_mask  : per-wrap non-empty (registered state)
//   issue_wrap_idx, issue_pop : head select and consume
//   issue_pc, issue_inst      : head of issue_wrap_idx (combinational read)
//   flush_valid, flush_wrap_idx : discard all entries of one wrap
//   overflow_err      : sticky, enqueue attempted on a full FIFO
// Optional: define IBUF_PERF_COUNTERS_EN to add perf_full_stall_cnt, a
// saturating count of cycles where a full wrap is skipped by a pop elsewhere.
module wrap_inst_buffer
  import wrap_inst_buffer_pkg::*;
#(
  parameter  int NUM_WRAPS = NUM_WRAPS_PER_CORE,
  parameter  int DEPTH     = 4,
  parameter  int SKID      = 1,
  localparam int IDX_W     = $clog2(NUM_WRAPS),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [IDX_W-1:0]     fetch_wrap_idx,
  input  logic [31:0]          fetch_pc,
  input  logic [31:0]          fetch_inst,
  output logic [NUM_WRAPS-1:0] ibuf_ready_mask,
  output logic [NUM_WRAPS-1:0] issue_valid_mask,
  input  logic [IDX_W-1:0]     issue_wrap_idx,
  input  logic                 issue_pop,
  output logic [31:0]          issue_pc,
  output logic [31:0]          issue_inst,
  input  logic                 flush_valid,
  input  logic [IDX_W-1:0]     flush_wrap_idx,
`ifdef IBUF_PERF_COUNTERS_EN
  output logic [31:0]          perf_full_stall_cnt,
`endif
  output logic                 overflow_err
);

  ibuf_entry_t          fetch_entry;
  ibuf_entry_t          heads  [NUM_WRAPS];
  logic [CNT_W-1:0]     counts [NUM_WRAPS];
  logic [NUM_WRAPS-1:0] ovf_vec;

  assign fetch_entry = '{pc: fetch_pc, inst: fetch_inst};

  for (genvar w = 0; w < NUM_WRAPS; w++) begin : g_wrap
    ibuf_wrap_fifo #(
      .DEPTH (DEPTH),
      .SKID  (SKID)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fetch_valid && (fetch_wrap_idx == IDX_W'(w))),
      .push_data (fetch_entry),
      .pop       (issue_pop && (issue_wrap_idx == IDX_W'(w))),
      .flush     (flush_valid && (flush_wrap_idx == IDX_W'(w))),
      .head      (heads[w]),
      .count     (counts[w]),
      .ready     (ibuf_ready_mask[w]),
      .overflow  (ovf_vec[w])
    );
    assign issue_valid_mask[w] = (counts[w] != '0);
  end

  assign issue_pc   = heads[issue_wrap_idx].pc;
  assign issue_inst = heads[issue_wrap_idx].inst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         overflow_err <= 1'b0;
    else if (|ovf_vec) overflow_err <= 1'b1;
  end

`ifdef IBUF_PERF_COUNTERS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic full_stall;

  always_comb begin
    full_stall = 1'b0;
    for (int w = 0; w < NUM_WRAPS; w++) begin
      if ((counts[w] == CNT_W'(DEPTH)) && issue_valid_mask[w] &&
          issue_pop && (issue_wrap_idx != IDX_W'(w)))
        full_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           perf_full_stall_cnt <= '0;
    else if (full_stall) perf_full_stall_cnt <= sat_inc(perf_full_stall_cnt);
  end
`endif

endmodule

// File: tb/tb_wrap_inst_buffer.sv
// Self-checking bench for wrap_inst_buffer: directed scenarios plus random
// traffic, checked against a queue-per-wrap reference model.
module tb_wrap_inst_buffer;

  localparam int NW    = 4;
  localparam int DEPTH = 4;
  localparam int SKID  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [1:0]  fetch_wrap_idx;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic [3:0]  ibuf_ready_mask;
  logic [3:0]  issue_valid_mask;
  logic [1:0]  issue_wrap_idx;
  logic        issue_pop;
  logic [31:0] issue_pc;
  logic [31:0] issue_inst;
  logic        flush_valid;
  logic [1:0]  flush_wrap_idx;
  logic        overflow_err;
`ifdef IBUF_PERF_COUNTERS_EN
  logic [31:0] perf_full_stall_cnt;
`endif

  wrap_inst_buffer #(.NUM_WRAPS(NW), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_valid      (fetch_valid),
    .fetch_wrap_idx   (fetch_wrap_idx),
    .fetch_pc         (fetch_pc),
    .fetch_inst       (fetch_inst),
    .ibuf_ready_mask  (ibuf_ready_mask),
    .issue_valid_mask (issue_valid_mask),
    .issue_wrap_idx   (issue_wrap_idx),
    .issue_pop        (issue_pop),
    .issue_pc         (issue_pc),
    .issue_inst       (issue_inst),
    .flush_valid      (flush_valid),
    .flush_wrap_idx   (flush_wrap_idx),
`ifdef IBUF_PERF_COUNTERS_EN
    .perf_full_stall_cnt (perf_full_stall_cnt),
`endif
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one queue of {pc, inst} per wrap, plus sticky overflow.
  logic [63:0] q [NW][$];
  bit          m_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++) q[w].delete();
    m_ovf = 1'b0;
  endtask

  task automatic drive_idle(input int iw);
    fetch_valid    = 1'b0;
    fetch_wrap_idx = 2'd0;
    fetch_pc       = 32'd0;
    fetch_inst     = 32'd0;
    issue_pop      = 1'b0;
    issue_wrap_idx = 2'(iw);
    flush_valid    = 1'b0;
    flush_wrap_idx = 2'd0;
  endtask

  task automatic check_model();
    logic [3:0] er, ev;
    int iw;
    for (int w = 0; w < NW; w++) begin
      er[w] = (q[w].size() < DEPTH - SKID);
      ev[w] = (q[w].size() != 0);
    end
    chk("ready_mask", ibuf_ready_mask, er);
    chk("valid_mask", issue_valid_mask, ev);
    chk("overflow_err", overflow_err, m_ovf);
    iw = int'(issue_wrap_idx);
    if (q[iw].size() != 0) begin
      chk("issue_pc", issue_pc, q[iw][0][63:32]);
      chk("issue_inst", issue_inst, q[iw][0][31:0]);
    end
  endtask

  // Apply one cycle's worth of rules to the model.
  task automatic model_step(input bit fv, input int fw, input logic [31:0] pc,
                            input logic [31:0] inst, input bit pop, input int iw,
                            input bit fl, input int flw);
    int pre [NW];
    for (int w = 0; w < NW; w++) pre[w] = q[w].size();
    if (pop && pre[iw] > 0) void'(q[iw].pop_front());
    if (fv && !(fl && flw == fw)) begin
      if (pre[fw] >= DEPTH) m_ovf = 1'b1;
      else q[fw].push_back({pc, inst});
    end
    if (fl) q[flw].delete();
  endtask

  task automatic cyc(input bit fv, input int fw, input logic [31:0] pc,
                     input bit pop, input int iw, input bit fl, input int flw);
    logic [31:0] inst;
    inst = pc ^ 32'hA5A5_0000;
    @(negedge clk);
    fetch_valid    = fv;
    fetch_wrap_idx = 2'(fw);
    fetch_pc       = pc;
    fetch_inst     = inst;
    issue_pop      = pop;
    issue_wrap_idx = 2'(iw);
    flush_valid    = fl;
    flush_wrap_idx = 2'(flw);
    #1 check_model();
    @(posedge clk);
    model_step(fv, fw, pc, inst, pop, iw, fl, flw);
  endtask

  task automatic push(input int fw, input logic [31:0] pc);
    cyc(1'b1, fw, pc, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic peek(input int iw);
    @(negedge clk);
    drive_idle(iw);
    #1 check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle(0);
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_ready", ibuf_ready_mask, 4'b1111);
    chk("rst_valid", issue_valid_mask, 4'b0000);
    chk("rst_ovf", overflow_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive_idle(0);
    model_clear();
    #2 reset = 1'b1;
    #1;
    chk("init_ready", ibuf_ready_mask, 4'b1111);
    chk("init_valid", issue_valid_mask, 4'b0000);
    chk("init_ovf", overflow_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // First push becomes visible one cycle later.
    push(2, 32'h100);
    peek(2);
    chk("t1_valid", issue_valid_mask, 4'b0100);
    chk("t1_pc", issue_pc, 32'h100);

    // Fill wrap 0: ready drops at DEPTH-SKID, overflow on the fifth push.
    do_reset();
    push(0, 32'h10); push(0, 32'h14); push(0, 32'h18);
    peek(0);
    chk("t2_ready0_low", ibuf_ready_mask[0], 1'b0);
    push(0, 32'h1C);
    peek(0);
    chk("t2_ovf_clear_at_4", overflow_err, 1'b0);
    push(0, 32'h20);
    peek(0);
    chk("t2_ovf_set", overflow_err, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 32'h0, 1'b1, 0, 1'b0, 0);
    peek(0);
    chk("t2_drained", issue_valid_mask, 4'b0000);
    chk("t2_ovf_sticky", overflow_err, 1'b1);

    // Simultaneous push and pop on a non-empty wrap.
    do_reset();
    push(1, 32'h200); push(1, 32'h204);
    cyc(1'b0, 1, 32'h0, 1'b1, 1, 1'b0, 0);
    cyc(1'b1, 1, 32'h208, 1'b1, 1, 1'b0, 0);
    peek(1);
    chk("t3_pc", issue_pc, 32'h208);
    chk("t3_valid", issue_valid_mask, 4'b0010);
    cyc(1'b0, 1, 32'h0, 1'b1, 1, 1'b0, 0);
    peek(1);
    chk("t3_count1", issue_valid_mask, 4'b0000);

    // Flush with same-cycle push; other wraps untouched.
    do_reset();
    push(0, 32'hA0);
    push(3, 32'h3A0); push(3, 32'h3A4); push(3, 32'h3A8);
    cyc(1'b1, 3, 32'h300, 1'b0, 0, 1'b1, 3);
    peek(3);
    chk("t4_valid", issue_valid_mask, 4'b0001);
    chk("t4_ovf", overflow_err, 1'b0);
    peek(0);
    chk("t4_w0_pc", issue_pc, 32'hA0);

    // Push and pop on an empty wrap: only the push takes effect.
    cyc(1'b1, 2, 32'h500, 1'b1, 2, 1'b0, 0);
    peek(2);
    chk("t5_valid", issue_valid_mask, 4'b0101);
    chk("t5_pc", issue_pc, 32'h500);

    // Asynchronous reset mid-stream, with a fetch in flight.
    do_reset();
    push(1, 32'h600); push(1, 32'h604);
    peek(1);
    @(negedge clk);
    fetch_valid    = 1'b1;
    fetch_wrap_idx = 2'd1;
    fetch_pc       = 32'h999;
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk("t6_valid", issue_valid_mask, 4'b0000);
    chk("t6_ready", ibuf_ready_mask, 4'b1111);
    @(negedge clk);
    drive_idle(1);
    reset = 1'b0;
    push(1, 32'h400);
    peek(1);
    chk("t6_pc", issue_pc, 32'h400);
    chk("t6_valid_after", issue_valid_mask, 4'b0010);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 65, int'($urandom_range(0, 3)), $urandom,
          $urandom_range(0, 99) < 45, int'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 6, int'($urandom_range(0, 3)));
    end
    peek(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
